result_to_digits: RTL and testbench

Sequential formatter that turns a signed two's-complement ALU result into per-digit display codes for the seven-segment decoder bank. It sits directly upstream of the seven-segment decoders: each 4-bit field of its `digits` output drives one decoder. Conversion uses an iterative shift-and-add-3 (double-dabble) engine with a start/done handshake. Outputs hold the last completed result between conversions.

---
 rtl/result_to_digits.sv | 92 +++++++++
 tb/tb_result_to_digits.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/result_to_digits.sv
// result_to_digits: signed ALU result to seven-segment digit codes via double-dabble; RESULT_TO_DIGITS_LZB_EN enables leading-zero blanking
module result_to_digits #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  ovf,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digits
);
   localparam int BW = 4*(DIGITS-1);
   localparam int CW = $clog2(WIDTH+1);
   localparam longint unsigned LIMIT = longint'(10)**(DIGITS-1) - 1;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    mag, mag_in;
   logic [BW-1:0]       bcd, bcd_adj;
   logic [CW-1:0]       cnt;
   logic                neg, ovl;
   logic [4*DIGITS-1:0] fmt;

   assign busy = state != IDLE;

   // next state and magnitude of the incoming value
   always_comb begin
      state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (cnt == CW'(1) ? FORMAT : SHIFT) : IDLE;
      mag_in    = value[WIDTH-1] ? -value : value;
   end

   // add-3 correction on every BCD nibble that would overflow when doubled
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS-1; i++)
         bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
   end

`ifdef RESULT_TO_DIGITS_LZB_EN
   int top;
   // blank leading zeros and park the minus sign just left of the top shown digit
   always_comb begin
      top = 0;
      for (int k = 1; k < DIGITS-1; k++)
         if (bcd[4*k+:4] != 4'd0) top = k;
      fmt = '1;
      for (int k = 0; k < DIGITS-1; k++)
         fmt[4*k+:4] = k <= top ? bcd[4*k+:4] : (neg && k == top + 1 ? 4'hA : 4'hF);
      fmt[4*(DIGITS-1)+:4] = neg && top == DIGITS-2 ? 4'hA : 4'hF;
   end
`else
   // all magnitude digits shown, sign in the top field
   always_comb begin
      fmt = {neg ? 4'hA : 4'hF, bcd};
   end
`endif

   // capture, shift engine and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         done   <= 1'b0;
         digits <= '1;
         mag    <= '0;
         bcd    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         ovl    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= state == FORMAT;
         if (state == IDLE && start) begin
            mag <= mag_in;
            bcd <= '0;
            cnt <= CW'(WIDTH);
            neg <= value[WIDTH-1];
            ovl <= ovf | (64'(mag_in) > LIMIT);
         end
         if (state == SHIFT) begin
            {bcd, mag} <= {bcd_adj, mag} << 1;
            cnt        <= cnt - CW'(1);
         end
         if (state == FORMAT)
            digits <= ovl ? {DIGITS{4'hB}} : fmt;
      end
   end
endmodule

// File: tb/tb_result_to_digits.sv
// tb_result_to_digits: scoreboard bench for result_to_digits (default parameters, either RESULT_TO_DIGITS_LZB_EN build)
module tb_result_to_digits;
   logic        clk = 1'b0;
   logic        rst_n, start, ovf, busy, done;
   logic [7:0]  value;
   logic [15:0] digits;
   int          checks = 0, errors = 0, cyc = 0, dones = 0, pushes = 0, st;
   logic [15:0] last_exp;
   logic [15:0] eq[$];
   int          sq[$];

   result_to_digits dut (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value),
      .ovf(ovf), .busy(busy), .done(done), .digits(digits)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] v, input logic o);
      int m, nd;
      logic [15:0] r;
      m = v[7] ? 256 - int'(v) : int'(v);
      if (o || m > 999) return 16'hBBBB;
      r = 16'hFFFF;
`ifdef RESULT_TO_DIGITS_LZB_EN
      nd = m >= 100 ? 3 : m >= 10 ? 2 : 1;
      for (int k = 0; k < nd; k++) r[4*k+:4] = 4'((m / (10**k)) % 10);
      if (v[7]) r[4*nd+:4] = 4'hA;
`else
      nd = 3;
      for (int k = 0; k < nd; k++) r[4*k+:4] = 4'((m / (10**k)) % 10);
      if (v[7]) r[15:12] = 4'hA;
`endif
      return r;
   endfunction

   task automatic push(input logic [7:0] v, input logic o, input int c);
      eq.push_back(model(v, o));
      sq.push_back(c);
      last_exp = model(v, o);
      pushes++;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && eq.size() > 0; i++) @(negedge clk);
      if (eq.size() != 0) begin
         chk("timeout", eq.size(), 0);
         eq.delete();
         sq.delete();
      end
   endtask

   task automatic conv(input logic [7:0] v, input logic o);
      @(negedge clk);
      value = v; ovf = o; start = 1'b1;
      push(v, o, cyc);
      @(negedge clk);
      start = 1'b0; value = 8'($urandom); ovf = 1'($urandom);
      chk("busy", busy, 1);
      drain();
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         dones++;
         if (eq.size() == 0) chk("spurious_done", done, 0);
         else begin
            chk("digits", digits, eq.pop_front());
            chk("latency", cyc - sq.pop_front() - 1, 9);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; value = '0; ovf = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_digits", digits, 16'hFFFF);
      rst_n = 1'b1;
      conv(8'd42, 1'b0);
      conv(8'hFB, 1'b0);
      conv(8'h80, 1'b0);
      conv(8'd127, 1'b0);
      conv(8'd0, 1'b0);
      conv(8'd17, 1'b1);
      conv(8'h9C, 1'b0);
      conv(8'd7, 1'b0);
      conv(8'hF6, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold", digits, last_exp);
      // reset during SHIFT
      @(negedge clk);
      value = 8'd99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_digits", digits, 16'hFFFF);
      @(negedge clk);
      rst_n = 1'b1;
      conv(8'd3, 1'b0);
      // second start at E3 is ignored
      @(negedge clk);
      value = 8'd55; ovf = 1'b0; start = 1'b1;
      push(8'd55, 1'b0, cyc);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      value = 8'd66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      // start held high: one result every 10 clocks
      @(negedge clk);
      st = cyc; value = 8'hE7; ovf = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) push(8'hE7, 1'b0, st + 10*i);
      repeat (30) @(negedge clk);
      start = 1'b0;
      drain();
      repeat (12) @(negedge clk);
      chk("done_count", dones, pushes);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
